eth_pkt_fifo: RTL and testbench

Parametrised packet buffer sitting between the 10G MAC receive AXI-Stream, which has no tready, and the eth_encap/transmit path. It generalises the plain loopback FIFO in data width, depth and buffering mode. In store-and-forward mode it releases only complete frames and discards errored frames. It also adds frame-atomic overflow dropping, cut-through truncation and drop statistics.

---
 rtl/eth_pkt_fifo.sv | 147 ++++++++++++++
 tb/tb_eth_pkt_fifo.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_pkt_fifo.sv
// Packet buffer between the MAC receive stream (no backpressure) and the transmit path.
// Store-and-forward mode releases only complete frames and can discard errored ones.
// Cut-through mode releases every beat immediately and truncates frames on overflow.
module eth_pkt_fifo #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned DEPTH      = 512,
    parameter bit          PKT_MODE   = 1'b1,
    parameter bit          DROP_BAD   = 1'b1
) (
    input  logic                    clk156,
    input  logic                    eth_rst_n,
    input  logic                    s_axis_tvalid,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tuser,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    output logic [$clog2(DEPTH):0]  fill_level,
    output logic [15:0]             drop_cnt,
    output logic [15:0]             bad_cnt
);
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned WW     = DATA_WIDTH + KEEP_WIDTH + 2;
    localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);
    localparam logic [AW:0] PtrOne = (AW + 1)'(1);

    typedef enum logic [1:0] {WrIdle, WrFrame, WrDrop} wr_state_e;

    wr_state_e       state_q, state_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     commit_ptr_q, commit_ptr_d;
    logic [AW:0]     rd_ptr_q;
    logic [15:0]     drop_cnt_q, drop_cnt_d;
    logic [15:0]     bad_cnt_q, bad_cnt_d;
    logic            drop_inc, bad_inc;
    logic [AW:0]     free;
    logic            mem_we;
    logic [WW-1:0]   mem_wdata;
    logic [WW-1:0]   mem_q [DEPTH];
    logic            out_valid_q;
    logic [WW-1:0]   out_word_q;
    logic            rd_en;

    // Space left counts words written but not yet fetched into the output stage.
    assign free = DepthW - (wr_ptr_q - rd_ptr_q);

    // Write FSM: accept, commit, rewind or drop each ingress beat.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        drop_inc     = 1'b0;
        bad_inc      = 1'b0;
        mem_we       = 1'b0;
        mem_wdata    = {s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        if (s_axis_tvalid) begin
            if (state_q == WrDrop) begin
                if (s_axis_tlast) state_d = WrIdle;
            end else if (free == '0) begin
                // No room: throw away whatever of this frame is still speculative.
                wr_ptr_d = commit_ptr_q;
                drop_inc = 1'b1;
                state_d  = s_axis_tlast ? WrIdle : WrDrop;
            end else if (!PKT_MODE && free == PtrOne && !s_axis_tlast) begin
                // Last slot in cut-through: close the frame as truncated.
                mem_we       = 1'b1;
                mem_wdata    = {1'b1, 1'b1, s_axis_tkeep, s_axis_tdata};
                wr_ptr_d     = wr_ptr_q + PtrOne;
                commit_ptr_d = wr_ptr_q + PtrOne;
                drop_inc     = 1'b1;
                state_d      = WrDrop;
            end else begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PtrOne;
                state_d  = s_axis_tlast ? WrIdle : WrFrame;
                if (!PKT_MODE) begin
                    commit_ptr_d = wr_ptr_q + PtrOne;
                end else if (s_axis_tlast) begin
                    if (DROP_BAD && s_axis_tuser) begin
                        wr_ptr_d = commit_ptr_q;
                        bad_inc  = 1'b1;
                    end else begin
                        commit_ptr_d = wr_ptr_q + PtrOne;
                    end
                end
            end
        end
        drop_cnt_d = (drop_inc && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
        bad_cnt_d  = (bad_inc && bad_cnt_q != 16'hFFFF) ? bad_cnt_q + 16'd1 : bad_cnt_q;
    end

    // Write-side state registers.
    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            state_q      <= WrIdle;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            drop_cnt_q   <= '0;
            bad_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            drop_cnt_q   <= drop_cnt_d;
            bad_cnt_q    <= bad_cnt_d;
        end
    end

    // Storage array, written at the speculative write position.
    always_ff @(posedge clk156) begin
        if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= mem_wdata;
    end

    // Fetch when a committed word exists and the output stage is empty or draining.
    assign rd_en = (rd_ptr_q != commit_ptr_q) && (!out_valid_q || m_axis_tready);

    // Synchronous RAM read doubles as the output stage; holds steady while stalled.
    always_ff @(posedge clk156 or negedge eth_rst_n) begin
        if (!eth_rst_n) begin
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_word_q  <= '0;
        end else if (rd_en) begin
            rd_ptr_q    <= rd_ptr_q + PtrOne;
            out_valid_q <= 1'b1;
            out_word_q  <= mem_q[rd_ptr_q[AW-1:0]];
        end else if (m_axis_tready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tdata  = out_word_q[DATA_WIDTH-1:0];
    assign m_axis_tkeep  = out_word_q[DATA_WIDTH +: KEEP_WIDTH];
    assign m_axis_tlast  = out_word_q[WW-2];
    assign m_axis_tuser  = out_word_q[WW-1];
    assign fill_level    = commit_ptr_q - rd_ptr_q;
    assign drop_cnt      = drop_cnt_q;
    assign bad_cnt       = bad_cnt_q;

endmodule

// File: tb/tb_eth_pkt_fifo.sv
// Bench for eth_pkt_fifo: a store-and-forward and a cut-through instance (both 16 deep)
// share one ingress stream and one tready; each is compared against a queue-based model.
module tb_eth_pkt_fifo;
    localparam int DW    = 64;
    localparam int KW    = 8;
    localparam int DEPTH = 16;
    localparam int WW    = DW + KW + 2;
    typedef logic [WW-1:0] word_t;

    logic          clk156 = 1'b0;
    logic          eth_rst_n = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tuser = 1'b0;
    logic          m_axis_tready = 1'b0;

    logic          sf_tvalid, sf_tlast, sf_tuser, ct_tvalid, ct_tlast, ct_tuser;
    logic [DW-1:0] sf_tdata, ct_tdata;
    logic [KW-1:0] sf_tkeep, ct_tkeep;
    logic [4:0]    sf_fill, ct_fill;
    logic [15:0]   sf_drop, sf_bad, ct_drop, ct_bad;

    logic          dv [2];
    word_t         dw [2];
    logic [4:0]    dfill [2];
    logic [15:0]   ddrop [2];
    logic [15:0]   dbad [2];

    assign dv[0] = sf_tvalid;  assign dw[0] = {sf_tuser, sf_tlast, sf_tkeep, sf_tdata};
    assign dv[1] = ct_tvalid;  assign dw[1] = {ct_tuser, ct_tlast, ct_tkeep, ct_tdata};
    assign dfill[0] = sf_fill; assign ddrop[0] = sf_drop; assign dbad[0] = sf_bad;
    assign dfill[1] = ct_fill; assign ddrop[1] = ct_drop; assign dbad[1] = ct_bad;

    eth_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PKT_MODE(1'b1), .DROP_BAD(1'b1)) u_sf (
        .clk156(clk156), .eth_rst_n(eth_rst_n),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tvalid(sf_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(sf_tdata),
        .m_axis_tkeep(sf_tkeep), .m_axis_tlast(sf_tlast), .m_axis_tuser(sf_tuser),
        .fill_level(sf_fill), .drop_cnt(sf_drop), .bad_cnt(sf_bad)
    );

    eth_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PKT_MODE(1'b0), .DROP_BAD(1'b1)) u_ct (
        .clk156(clk156), .eth_rst_n(eth_rst_n),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .m_axis_tvalid(ct_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(ct_tdata),
        .m_axis_tkeep(ct_tkeep), .m_axis_tlast(ct_tlast), .m_axis_tuser(ct_tuser),
        .fill_level(ct_fill), .drop_cnt(ct_drop), .bad_cnt(ct_bad)
    );

    always #5 clk156 = ~clk156;

    // Reference model: committed-unfetched words, pending frame words, output slot.
    word_t sf_ram[$];
    word_t sf_spec[$];
    word_t ct_ram[$];
    logic  mv [2];
    word_t mo [2];
    int    mst [2];    // 0 idle, 1 in frame, 2 discarding
    int    mdrop [2];
    int    mbad [2];

    int    n_checks = 0;
    int    n_fail = 0;
    int    rdy_mode = 1;   // 0 low, 1 high, 2 random
    string pfx [2] = '{"sf_", "ct_"};

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        sf_ram.delete();
        sf_spec.delete();
        ct_ram.delete();
        for (int m = 0; m < 2; m++) begin
            mv[m] = 1'b0; mo[m] = '0; mst[m] = 0; mdrop[m] = 0; mbad[m] = 0;
        end
    endtask

    task automatic bump(inout int cnt);
        if (cnt < 16'hFFFF) cnt++;
    endtask

    task automatic model_step(input int m);
        word_t w;
        int    stored;
        int    free;
        int    avail;
        stored = (m == 0) ? sf_ram.size() + sf_spec.size() : ct_ram.size();
        free   = DEPTH - stored;
        avail  = (m == 0) ? sf_ram.size() : ct_ram.size();
        // Egress: refill the output slot from what was committed before this edge.
        if (avail > 0 && (!mv[m] || m_axis_tready)) begin
            if (m == 0) mo[m] = sf_ram.pop_front();
            else        mo[m] = ct_ram.pop_front();
            mv[m] = 1'b1;
        end else if (m_axis_tready) begin
            mv[m] = 1'b0;
        end
        if (!s_axis_tvalid) return;
        w = {s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata};
        if (mst[m] == 2) begin
            if (s_axis_tlast) mst[m] = 0;
        end else if (free == 0) begin
            if (m == 0) sf_spec.delete();
            bump(mdrop[m]);
            mst[m] = s_axis_tlast ? 0 : 2;
        end else if (m == 1 && free == 1 && !s_axis_tlast) begin
            ct_ram.push_back({2'b11, s_axis_tkeep, s_axis_tdata});
            bump(mdrop[m]);
            mst[m] = 2;
        end else begin
            mst[m] = s_axis_tlast ? 0 : 1;
            if (m == 1) begin
                ct_ram.push_back(w);
            end else begin
                sf_spec.push_back(w);
                if (s_axis_tlast) begin
                    if (s_axis_tuser) bump(mbad[m]);
                    else foreach (sf_spec[i]) sf_ram.push_back(sf_spec[i]);
                    sf_spec.delete();
                end
            end
        end
    endtask

    task automatic check_outputs();
        for (int m = 0; m < 2; m++) begin
            check_eq({pfx[m], "tvalid"}, dv[m], mv[m]);
            if (mv[m]) check_eq({pfx[m], "payload"}, dw[m], mo[m]);
            check_eq({pfx[m], "fill_level"}, dfill[m], (m == 0) ? sf_ram.size() : ct_ram.size());
            check_eq({pfx[m], "drop_cnt"}, ddrop[m], mdrop[m]);
            check_eq({pfx[m], "bad_cnt"}, dbad[m], mbad[m]);
        end
    endtask

    // One clock: check state after the last edge, drive inputs, advance model to next edge.
    task automatic tick(input logic v, input logic [DW-1:0] d, input logic [KW-1:0] k,
                        input logic l, input logic u);
        @(negedge clk156);
        check_outputs();
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        s_axis_tuser  = u;
        m_axis_tready = (rdy_mode == 2) ? 1'($urandom_range(0, 1)) : (rdy_mode == 1);
        model_step(0);
        model_step(1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int len, input logic user, input logic [KW-1:0] klast);
        for (int i = 0; i < len; i++) begin
            tick(1'b1, {$urandom(), $urandom()}, (i == len - 1) ? klast : 8'hFF,
                 i == len - 1, (i == len - 1) ? user : 1'b0);
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk156);
        check_outputs();
        check_eq("sf_reset_payload", dw[0], '0);
        check_eq("ct_reset_payload", dw[1], '0);
        eth_rst_n = 1'b1;

        // Short frame with partial keep on the last beat.
        rdy_mode = 1;
        send_frame(3, 1'b0, 8'h0F);
        idle(8);

        // Errored frame followed by a good one.
        send_frame(4, 1'b1, 8'hFF);
        send_frame(2, 1'b0, 8'h3F);
        idle(8);

        // Two 10-beat frames into a stalled output.
        rdy_mode = 0;
        send_frame(10, 1'b0, 8'hFF);
        send_frame(10, 1'b0, 8'hFF);
        idle(3);
        rdy_mode = 1;
        idle(25);

        // Oversized frame while stalled, then a normal frame once space frees.
        rdy_mode = 0;
        send_frame(20, 1'b0, 8'hFF);
        rdy_mode = 1;
        idle(20);
        send_frame(5, 1'b0, 8'h01);
        idle(10);

        // Back-to-back frames with the sink always ready.
        for (int f = 0; f < 6; f++) send_frame(8, 1'b0, 8'hFF);
        idle(20);

        // Random frames, gaps, errors and tready.
        rdy_mode = 2;
        for (int f = 0; f < 60; f++) begin
            send_frame($urandom_range(1, 20), $urandom_range(0, 3) == 0,
                       8'($urandom_range(1, 255)));
            idle($urandom_range(0, 3));
        end
        rdy_mode = 1;
        idle(40);

        // Reset asserted mid-frame between clock edges.
        rdy_mode = 0;
        send_frame(3, 1'b0, 8'hFF);
        for (int i = 0; i < 5; i++) tick(1'b1, {$urandom(), $urandom()}, 8'hFF, 1'b0, 1'b0);
        @(negedge clk156);
        check_outputs();
        eth_rst_n = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check_eq("sf_rst_payload", dw[0], '0);
        check_eq("ct_rst_payload", dw[1], '0);
        repeat (2) @(negedge clk156);
        eth_rst_n = 1'b1;
        rdy_mode = 1;
        send_frame(6, 1'b0, 8'h7F);
        idle(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
